// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Owns the single write port of the register file. Two producers compete:
//   the ALU (fixed priority, never stalled) and the load-return path
//   (buffered in a DEPTH-entry FIFO, drained in non-ALU cycles). A pending
//   scoreboard marks registers with an outstanding load so upstream issue
//   logic can stall on hazards.
//
// Ports
//   Clock, Reset                    rising-edge clock, async active-low reset
//   AluValid/AluDest/AluData        ALU result (highest priority)
//   LoadValid/LoadDest/LoadData     load return offer
//   LoadReady                       load accepted when LoadValid && LoadReady
//   IssueLoad/IssueDest             load issued upstream, sets Pending bit
//   Pending                         one bit per register, outstanding load
//   WriteEnable/SelectInput/
//   WriteData/WriteFromLoad         registered register-file write port
module writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    AluValid,
    input  logic [ADDR_W-1:0]       AluDest,
    input  logic [DATA_W-1:0]       AluData,
    input  logic                    LoadValid,
    input  logic [ADDR_W-1:0]       LoadDest,
    input  logic [DATA_W-1:0]       LoadData,
    output logic                    LoadReady,
    input  logic                    IssueLoad,
    input  logic [ADDR_W-1:0]       IssueDest,
    output logic [(1<<ADDR_W)-1:0]  Pending,
    output logic                    WriteEnable,
    output logic [ADDR_W-1:0]       SelectInput,
    output logic [DATA_W-1:0]       WriteData,
    output logic                    WriteFromLoad
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_nonempty;
    logic              accept;
    logic              sel_alu, sel_fifo, sel_bypass;
    logic              push, pop;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic [NREG-1:0]   set_mask, clr_mask;

    assign LoadReady     = (count < CNT_W'(DEPTH));
    assign fifo_nonempty = (count != '0);
    assign accept        = LoadValid && LoadReady;
    assign head_dest     = dest_mem[rd_ptr];
    assign head_data     = data_mem[rd_ptr];

    // Source priority: ALU, then FIFO head, then direct bypass of an
    // incoming load (only when nothing older is buffered, keeping order).
    always_comb begin
        sel_alu    = AluValid;
        sel_fifo   = !AluValid && fifo_nonempty;
        sel_bypass = !AluValid && !fifo_nonempty && accept;
        pop        = sel_fifo;
        push       = accept && !sel_bypass;
    end

    // Scoreboard: set beats clear when both target the same register.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (IssueLoad)
            set_mask = NREG'(1) << IssueDest;
        if (sel_fifo)
            clr_mask = NREG'(1) << head_dest;
        else if (sel_bypass)
            clr_mask = NREG'(1) << LoadDest;
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge Clock) begin
        if (push) begin
            dest_mem[wr_ptr] <= LoadDest;
            data_mem[wr_ptr] <= LoadData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            Pending <= '0;
        else
            Pending <= (Pending & ~clr_mask) | set_mask;
    end

    // Select/data hold their last value on idle cycles.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            WriteEnable   <= 1'b0;
            SelectInput   <= '0;
            WriteData     <= '0;
            WriteFromLoad <= 1'b0;
        end else if (sel_alu) begin
            WriteEnable   <= 1'b1;
            SelectInput   <= AluDest;
            WriteData     <= AluData;
            WriteFromLoad <= 1'b0;
        end else if (sel_fifo) begin
            WriteEnable   <= 1'b1;
            SelectInput   <= head_dest;
            WriteData     <= head_data;
            WriteFromLoad <= 1'b1;
        end else if (sel_bypass) begin
            WriteEnable   <= 1'b1;
            SelectInput   <= LoadDest;
            WriteData     <= LoadData;
            WriteFromLoad <= 1'b1;
        end else begin
            WriteEnable   <= 1'b0;
            WriteFromLoad <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  dest;
        logic [15:0] data;
    } ld_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        AluValid = 1'b0;
    logic [3:0]  AluDest = '0;
    logic [15:0] AluData = '0;
    logic        LoadValid = 1'b0;
    logic [3:0]  LoadDest = '0;
    logic [15:0] LoadData = '0;
    logic        LoadReady;
    logic        IssueLoad = 1'b0;
    logic [3:0]  IssueDest = '0;
    logic [15:0] Pending;
    logic        WriteEnable;
    logic [3:0]  SelectInput;
    logic [15:0] WriteData;
    logic        WriteFromLoad;

    writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .AluValid(AluValid), .AluDest(AluDest), .AluData(AluData),
        .LoadValid(LoadValid), .LoadDest(LoadDest), .LoadData(LoadData),
        .LoadReady(LoadReady),
        .IssueLoad(IssueLoad), .IssueDest(IssueDest),
        .Pending(Pending),
        .WriteEnable(WriteEnable), .SelectInput(SelectInput),
        .WriteData(WriteData), .WriteFromLoad(WriteFromLoad)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered loads plus expected write port.
    ld_t         q[$];
    ld_t         offers[$];
    ld_t         wlog[$];
    logic [15:0] m_pend = '0;
    logic        m_we = 1'b0, m_fl = 1'b0, m_acc = 1'b0;
    logic [3:0]  m_sel = '0;
    logic [15:0] m_data = '0;
    int          alu_writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        ld_t         e;
        logic        bypass;
        logic [15:0] np;
        #1;
        chk("load_ready", 32'(LoadReady), 32'(q.size() < DEPTH));
        m_acc  = LoadValid && (q.size() < DEPTH);
        bypass = 1'b0;
        np     = m_pend;
        if (AluValid) begin
            m_we = 1'b1; m_sel = AluDest; m_data = AluData; m_fl = 1'b0;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            m_we = 1'b1; m_sel = e.dest; m_data = e.data; m_fl = 1'b1;
            np[e.dest] = 1'b0;
        end else if (m_acc) begin
            bypass = 1'b1;
            m_we = 1'b1; m_sel = LoadDest; m_data = LoadData; m_fl = 1'b1;
            np[LoadDest] = 1'b0;
        end else begin
            m_we = 1'b0; m_fl = 1'b0;
        end
        if (m_acc && !bypass)
            q.push_back({LoadDest, LoadData});
        if (IssueLoad)
            np[IssueDest] = 1'b1;
        @(posedge Clock);
        #1;
        m_pend = np;
        chk("write_enable", 32'(WriteEnable), 32'(m_we));
        chk("select_input", 32'(SelectInput), 32'(m_sel));
        chk("write_data", 32'(WriteData), 32'(m_data));
        if (m_we)
            chk("write_from_load", 32'(WriteFromLoad), 32'(m_fl));
        chk("pending", 32'(Pending), 32'(m_pend));
        if (WriteEnable && WriteFromLoad)
            wlog.push_back({SelectInput, WriteData});
        if (WriteEnable && !WriteFromLoad)
            alu_writes++;
    endtask

    // One cycle; the load producer keeps its head offer until accepted.
    task automatic drive(input logic av, input logic [3:0] ad, input logic [15:0] adat,
                         input logic il, input logic [3:0] id);
        AluValid  = av;
        AluDest   = ad;
        AluData   = adat;
        IssueLoad = il;
        IssueDest = id;
        LoadValid = (offers.size() > 0);
        if (offers.size() > 0) begin
            LoadDest = offers[0].dest;
            LoadData = offers[0].data;
        end
        step();
        if (m_acc)
            void'(offers.pop_front());
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (offers.size() > 0 || q.size() > 0); i++)
            drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        chk("drain_bound", 32'(offers.size() + q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_we", 32'(WriteEnable), 32'd0);
        chk("rst_sel", 32'(SelectInput), 32'd0);
        chk("rst_data", 32'(WriteData), 32'd0);
        chk("rst_fl", 32'(WriteFromLoad), 32'd0);
        chk("rst_pending", 32'(Pending), 32'd0);
        chk("rst_ready", 32'(LoadReady), 32'd1);
        @(posedge Clock);
        #1;
        Reset = 1'b1;

        // 1: single ALU write, then idle
        drive(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0);
        chk("t1_we", 32'(WriteEnable), 32'd1);
        chk("t1_sel", 32'(SelectInput), 32'd3);
        chk("t1_data", 32'(WriteData), 32'hBEEF);
        chk("t1_fl", 32'(WriteFromLoad), 32'd0);
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        chk("t1_idle_we", 32'(WriteEnable), 32'd0);

        // 2: issue to r5, then bypassed load return clears it
        drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd5);
        chk("t2_pend_set", 32'(Pending[5]), 32'd1);
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        chk("t2_pend_hold", 32'(Pending[5]), 32'd1);
        offers.push_back({4'd5, 16'h1234});
        drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        chk("t2_we", 32'(WriteEnable), 32'd1);
        chk("t2_sel", 32'(SelectInput), 32'd5);
        chk("t2_data", 32'(WriteData), 32'h1234);
        chk("t2_fl", 32'(WriteFromLoad), 32'd1);
        chk("t2_pend_clr", 32'(Pending[5]), 32'd0);

        // 3: ALU busy 6 cycles against 5 back-to-back loads
        wlog.delete();
        alu_writes = 0;
        offers.push_back({4'd1, 16'hA001});
        offers.push_back({4'd2, 16'hA002});
        offers.push_back({4'd3, 16'hA003});
        offers.push_back({4'd4, 16'hA004});
        offers.push_back({4'd6, 16'hA006});
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(8 + i), 16'(16'hC000 + i), 1'b0, 4'd0);
            if (i == 4)
                chk("t3_full_ready", 32'(LoadReady), 32'd0);
        end
        chk("t3_held_offer", 32'(offers.size()), 32'd1);
        drain();
        chk("t3_alu_writes", 32'(alu_writes), 32'd6);
        chk("t3_nloads", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5) begin
            chk("t3_ord0", 32'(wlog[0].dest), 32'd1);
            chk("t3_ord1", 32'(wlog[1].dest), 32'd2);
            chk("t3_ord2", 32'(wlog[2].dest), 32'd3);
            chk("t3_ord3", 32'(wlog[3].dest), 32'd4);
            chk("t3_ord4", 32'(wlog[4].dest), 32'd6);
        end

        // 4: set and clear of r7 in the same cycle, set wins
        offers.push_back({4'd7, 16'h0777});
        drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
        chk("t4_we", 32'(WriteEnable), 32'd1);
        chk("t4_pend7", 32'(Pending[7]), 32'd1);

        // 5: reset mid-operation with three buffered loads
        for (int i = 0; i < 3; i++)
            offers.push_back({4'(i + 9), 16'(16'hD000 + i)});
        for (int i = 0; i < 3; i++)
            drive(1'b1, 4'd12, 16'(16'hE000 + i), 1'b0, 4'd0);
        chk("t5_buffered", 32'(q.size()), 32'd3);
        #2;
        Reset = 1'b0;
        #1;
        chk("t5_we", 32'(WriteEnable), 32'd0);
        chk("t5_sel", 32'(SelectInput), 32'd0);
        chk("t5_data", 32'(WriteData), 32'd0);
        chk("t5_fl", 32'(WriteFromLoad), 32'd0);
        chk("t5_pending", 32'(Pending), 32'd0);
        chk("t5_ready", 32'(LoadReady), 32'd1);
        q.delete();
        offers.delete();
        wlog.delete();
        m_pend = '0; m_we = 1'b0; m_fl = 1'b0; m_sel = '0; m_data = '0;
        AluValid = 1'b0; LoadValid = 1'b0; IssueLoad = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        chk("t5_no_stale", 32'(wlog.size()), 32'd0);

        // 6: 12 sequential loads through a full FIFO, pointer wrap
        wlog.delete();
        for (int i = 0; i < 12; i++)
            offers.push_back({4'(i), 16'(i)});
        for (int i = 0; i < 6; i++)
            drive(1'b1, 4'd15, 16'(16'hF000 + i), 1'b0, 4'd0);
        drain();
        chk("t6_nloads", 32'(wlog.size()), 32'd12);
        for (int i = 0; i < 12 && i < wlog.size(); i++)
            chk("t6_order", 32'(wlog[i].data), 32'(i));

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (offers.size() < 2 && $urandom_range(0, 1) == 0)
                offers.push_back({4'($urandom_range(0, 15)), 16'($urandom)});
            drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 16'($urandom),
                  $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Drives the single write port of the 16x16 register file (WriteEnable / SelectInput / data) from two result producers: the ALU and the memory load-return path.
- ALU results have fixed priority and are never stalled. Load returns are buffered in a small FIFO and written in free slots.
- A 16-bit pending scoreboard tracks registers with outstanding loads, so issue logic upstream can stall on RAW/WAW hazards.

Parameters:
DEPTH, 4, load-return FIFO entries (power of two, >=2)
DATA_W, 16, register data width
ADDR_W, 4, register select width (16 registers)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
AluValid  input  1  ALU result present this cycle
AluDest  input  ADDR_W  ALU destination register
AluData  input  DATA_W  ALU result
LoadValid  input  1  load return offered
LoadDest  input  ADDR_W  load destination register
LoadData  input  DATA_W  load data
LoadReady  output  1  load return accepted when LoadValid&&LoadReady
IssueLoad  input  1  a load is issued this cycle
IssueDest  input  ADDR_W  destination of the issued load
Pending  output  16  bit n = register n has an outstanding load
WriteEnable  output  1  register-file write enable (registered)
SelectInput  output  ADDR_W  register-file write select (registered)
WriteData  output  DATA_W  register-file write data (registered)
WriteFromLoad  output  1  current write comes from the load path (registered)

Behaviour:
- Reset (async, Reset=0): WriteEnable=0, SelectInput=0, WriteData=0, WriteFromLoad=0, Pending=0, FIFO count=0, read/write pointers=0. Effective immediately, mid-operation included; buffered loads are discarded.
- LoadReady is combinational: 1 iff FIFO count < DEPTH. It reads 1 out of reset.
- Write-source selection, evaluated every cycle in priority order:
  1. AluValid=1: ALU wins.
  2. Else FIFO non-empty: FIFO head wins (pop).
  3. Else LoadValid&&LoadReady: incoming load bypasses the FIFO and is written directly.
  4. Else: no write.
- Write outputs are registered and take effect on the next rising edge after selection (1-cycle latency). WriteEnable=0 when there is no write; SelectInput/WriteData then hold their previous values.
- An accepted load not taken by bypass is pushed to the FIFO.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - FIFO order is strict: loads are written in acceptance order.
- When the FIFO is full, LoadReady=0, no push occurs, and the producer must hold its data. An ALU write in the same cycle still proceeds; the head pops only in a non-ALU cycle.
- Pending scoreboard:
  - IssueLoad sets bit IssueDest at the clock edge.
  - Launching a load write (a load selected as source) clears bit LoadDest / head-dest at the same edge.
  - If set and clear hit the same bit in one cycle, set wins.
  - Two outstanding loads to one register are illegal for upstream; the bit clears on the first write.
- An ALU write to a register with Pending=1 is written normally. Hazard avoidance is upstream's responsibility; the block itself does not flag it.
- Register 0 gets no special treatment.
- A load result is written to the register file at most DEPTH+1 non-ALU cycles after acceptance.

Test Plan:
1. Reset, then AluValid=1, AluDest=3, AluData=16'hBEEF for one cycle -> next edge WriteEnable=1, SelectInput=3, WriteData=BEEF, WriteFromLoad=0; the following cycle WriteEnable=0.
2. IssueLoad to register 5, later LoadValid with dest 5, data 16'h1234, no ALU activity -> Pending[5]=1 until the bypass write; write appears 1 cycle after acceptance with WriteFromLoad=1, and Pending[5]=0 on the same edge.
3. AluValid held for 6 cycles while 5 loads (dests 1,2,3,4,6) are offered back-to-back -> LoadReady drops after 4 accepts. When the ALU goes idle, writes occur in order 1,2,3,4, then 6 is accepted and written last. No ALU write is lost.
4. Same cycle: IssueLoad to register 7 and load write launched to register 7 -> Pending[7] remains 1.
5. FIFO holding 3 entries, Reset pulsed low mid-cycle -> outputs, Pending and count go to 0 immediately. After release, LoadReady=1 and no stale writes appear.
6. Full FIFO with push and pop in the same cycle after an ALU burst ends -> count stays DEPTH-1 to DEPTH per rule, and pointer wrap preserves ordering across 12 sequential loads (data 0..11 written in order).
